dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer in front of a
// 256 x 64-bit data memory with synchronous write and registered read.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP, so one access completes
// every four cycles, and the granted port sees a single-cycle ack.
// Optional feature macro: DMEM_ARB_BOUNDS_EN. When it is defined, an access
// with addr >= DEPTH is not sent to memory; it is acked with err=1 two
// cycles after the request is sampled. When it is undefined, no bounds
// check is made, err outputs stay 0, and every address goes to memory.
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

`ifdef DMEM_ARB_BOUNDS_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q;
    logic                gnt_q;         // granted port id
    logic                we_q;          // granted access is a write
    logic                oob_q;         // granted access was out of range
    logic                last_grant_q;  // port served by the last completed access
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic                r0_ack_q;
    logic                r1_ack_q;
    logic                r0_err_q;
    logic                r1_err_q;
    logic [DATA_W-1:0]   r0_rdata_q;
    logic [DATA_W-1:0]   r1_rdata_q;
    logic                busy_q;

    logic                req_any_d;
    logic                gnt_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                oob_d;

    // Round-robin pick between the two requesters and mux the winner's fields.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch so no latch is inferred.
        req_any_d = r0_req | r1_req;
        // Port 1 wins only when it asks alone, or on a tie when port 0 went last.
        gnt_d     = r1_req & (~r0_req | ~last_grant_q);
        we_d      = gnt_d ? r1_we    : r0_we;
        addr_d    = gnt_d ? r1_addr  : r0_addr;
        wdata_d   = gnt_d ? r1_wdata : r0_wdata;
        oob_d     = BOUNDS_EN & (addr_d >= DEPTH_A);
    end

    // Access sequencer: state, strobes, acks and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            oob_q        <= 1'b0;
            last_grant_q <= 1'b1;  // so port 0 wins the first tie
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            r0_err_q     <= 1'b0;
            r1_err_q     <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses unless set below.
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            r0_ack_q    <= 1'b0;
            r1_ack_q    <= 1'b0;
            r0_err_q    <= 1'b0;
            r1_err_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (req_any_d) begin
                        gnt_q       <= gnt_d;
                        we_q        <= we_d;
                        oob_q       <= oob_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        busy_q      <= 1'b1;
                        if (oob_d) begin
                            // No memory cycle: one holding cycle, then RESP,
                            // which gives the two-cycle error latency.
                            state_q <= WAIT;
                        end else begin
                            mem_write_q <= we_d;
                            mem_read_q  <= ~we_d;
                            state_q     <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    // Memory samples the strobes on this edge.
                    state_q <= WAIT;
                end

                WAIT: begin
                    // mem_rdata is valid now for a read issued last cycle.
                    if (!we_q && !oob_q) begin
                        if (gnt_q) r1_rdata_q <= mem_rdata;
                        else       r0_rdata_q <= mem_rdata;
                    end
                    if (gnt_q) begin
                        r1_ack_q <= 1'b1;
                        r1_err_q <= oob_q;
                    end else begin
                        r0_ack_q <= 1'b1;
                        r0_err_q <= oob_q;
                    end
                    last_grant_q <= gnt_q;
                    state_q      <= RESP;
                end

                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign r0_ack    = r0_ack_q;
    assign r1_ack    = r1_ack_q;
    assign r0_err    = r0_err_q;
    assign r1_err    = r1_err_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// 256 x 64-bit memory (synchronous write, registered read).
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        r0_req, r0_we;
    logic [63:0] r0_addr, r0_wdata;
    logic        r0_ack, r0_err;
    logic [63:0] r0_rdata;
    logic        r1_req, r1_we;
    logic [63:0] r1_addr, r1_wdata;
    logic        r1_ack, r1_err;
    logic [63:0] r1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] D5 = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] D1 = 64'h1111_0000_AAAA_0001;
    localparam logic [63:0] D2 = 64'h2222_0000_BBBB_0002;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_ack    (r0_ack),
        .r0_rdata  (r0_rdata),
        .r0_err    (r0_err),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_ack    (r1_ack),
        .r1_rdata  (r1_rdata),
        .r1_err    (r1_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory.
    logic [63:0] mem [256];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // r1 write: request, three cycles to ack, then drop.
    task automatic r1_write(input logic [63:0] a, input logic [63:0] d);
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = a; r1_wdata = d;
        tick(); tick(); tick();
        check("r1_write_ack", {63'd0, r1_ack}, 64'd1);
        r1_req = 1'b0; r1_we = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
        tick(); tick();

        // ---- reset state
        check("rst_busy",     {63'd0, busy},      64'd0);
        check("rst_mem_rd",   {63'd0, mem_read},  64'd0);
        check("rst_mem_wr",   {63'd0, mem_write}, 64'd0);
        check("rst_r0_ack",   {63'd0, r0_ack},    64'd0);
        check("rst_r1_ack",   {63'd0, r1_ack},    64'd0);
        check("rst_mem_addr", mem_addr,           64'd0);
        check("rst_r0_rdata", r0_rdata,           64'd0);
        check("rst_r1_rdata", r1_rdata,           64'd0);
        rst = 1'b0;
        tick();

        // ---- r0 write addr 5
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 64'd5; r0_wdata = D5;
        tick();  // t+1: ISSUE
        check("wr_issue_write", {63'd0, mem_write}, 64'd1);
        check("wr_issue_read",  {63'd0, mem_read},  64'd0);
        check("wr_issue_addr",  mem_addr,           64'd5);
        check("wr_issue_wdata", mem_wdata,          D5);
        check("wr_issue_busy",  {63'd0, busy},      64'd1);
        tick();  // t+2: WAIT
        check("wr_wait_write",  {63'd0, mem_write}, 64'd0);
        check("wr_wait_ack",    {63'd0, r0_ack},    64'd0);
        tick();  // t+3: RESP
        check("wr_resp_ack",    {63'd0, r0_ack},    64'd1);
        check("wr_resp_err",    {63'd0, r0_err},    64'd0);
        check("wr_resp_rdata",  r0_rdata,           64'd0);
        check("wr_resp_r1ack",  {63'd0, r1_ack},    64'd0);
        r0_req = 1'b0; r0_we = 1'b0;
        tick();  // IDLE
        check("wr_idle_ack",    {63'd0, r0_ack},    64'd0);
        check("wr_idle_busy",   {63'd0, busy},      64'd0);

        // ---- r0 read addr 5
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 64'd5;
        tick();
        check("rd_issue_read",  {63'd0, mem_read},  64'd1);
        check("rd_issue_write", {63'd0, mem_write}, 64'd0);
        check("rd_issue_addr",  mem_addr,           64'd5);
        tick();
        check("rd_wait_read",   {63'd0, mem_read},  64'd0);
        tick();
        check("rd_resp_ack",    {63'd0, r0_ack},    64'd1);
        check("rd_resp_rdata",  r0_rdata,           D5);
        check("rd_resp_r1ack",  {63'd0, r1_ack},    64'd0);
        r0_req = 1'b0;
        tick();

        // ---- r1 writes to addresses 1 and 2; r1 rdata untouched by writes
        r1_write(64'd1, D1);
        r1_write(64'd2, D2);
        check("r1_wr_rdata_hold", r1_rdata, 64'd0);
        check("r1_wr_err",        {63'd0, r1_err}, 64'd0);

        // ---- both requesters held high: r0 (addr 1), r1 (addr 2), r0 again
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 64'd1;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 64'd2;
        tick();  // c+1
        check("rr_g0_addr",   mem_addr,          64'd1);
        check("rr_g0_read",   {63'd0, mem_read}, 64'd1);
        tick(); tick();  // c+3
        check("rr_g0_ack0",   {63'd0, r0_ack},   64'd1);
        check("rr_g0_ack1",   {63'd0, r1_ack},   64'd0);
        check("rr_g0_rdata",  r0_rdata,          D1);
        tick();  // c+4 IDLE
        check("rr_idle_ack0", {63'd0, r0_ack},   64'd0);
        check("rr_idle_busy", {63'd0, busy},     64'd0);
        tick();  // c+5
        check("rr_g1_addr",   mem_addr,          64'd2);
        tick(); tick();  // c+7
        check("rr_g1_ack1",   {63'd0, r1_ack},   64'd1);
        check("rr_g1_ack0",   {63'd0, r0_ack},   64'd0);
        check("rr_g1_rdata",  r1_rdata,          D2);
        tick(); tick();  // c+9
        check("rr_g2_addr",   mem_addr,          64'd1);
        tick(); tick();  // c+11
        check("rr_g2_ack0",   {63'd0, r0_ack},   64'd1);
        check("rr_g2_ack1",   {63'd0, r1_ack},   64'd0);
        r0_req = 1'b0; r1_req = 1'b0;
        tick(); tick();
        check("rr_end_busy",  {63'd0, busy},     64'd0);

        // ---- r1 request arrives while r0 access is in WAIT
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 64'd2;
        tick();  // s+1 ISSUE
        tick();  // s+2 WAIT
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 64'd1;
        tick();  // s+3 RESP
        check("late_r0_ack",   {63'd0, r0_ack},   64'd1);
        check("late_r0_rdata", r0_rdata,          D2);
        check("late_r1_noack", {63'd0, r1_ack},   64'd0);
        r0_req = 1'b0;
        tick();  // s+4 IDLE
        check("late_idle",     {63'd0, busy},     64'd0);
        tick();  // s+5 ISSUE for r1
        check("late_r1_read",  {63'd0, mem_read}, 64'd1);
        check("late_r1_addr",  mem_addr,          64'd1);
        tick();
        check("late_r1_early", {63'd0, r1_ack},   64'd0);
        tick();  // s+7
        check("late_r1_ack",   {63'd0, r1_ack},   64'd1);
        check("late_r1_rdata", r1_rdata,          D1);
        r1_req = 1'b0;
        tick();

        // ---- reset during WAIT of a read, then a normal read
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 64'd5;
        tick();  // u+1 ISSUE
        tick();  // u+2 WAIT
        rst = 1'b1;
        tick();  // u+3 after reset
        check("rstw_busy",   {63'd0, busy},      64'd0);
        check("rstw_read",   {63'd0, mem_read},  64'd0);
        check("rstw_write",  {63'd0, mem_write}, 64'd0);
        check("rstw_ack",    {63'd0, r0_ack},    64'd0);
        check("rstw_rdata",  r0_rdata,           64'd0);
        rst = 1'b0;
        tick();  // u+4 ISSUE
        check("rstw_re_read", {63'd0, mem_read}, 64'd1);
        tick(); tick();  // u+6
        check("rstw_re_ack",   {63'd0, r0_ack},  64'd1);
        check("rstw_re_rdata", r0_rdata,         D5);
        r0_req = 1'b0;
        tick();

        // ---- r1 read of address 300 (beyond the 256-word depth)
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 64'd300;
        tick();  // v+1
`ifdef DMEM_ARB_BOUNDS_EN
        check("oob_no_read",  {63'd0, mem_read}, 64'd0);
        check("oob_busy",     {63'd0, busy},     64'd1);
        check("oob_early",    {63'd0, r1_ack},   64'd0);
        tick();  // v+2
        check("oob_ack",      {63'd0, r1_ack},   64'd1);
        check("oob_err",      {63'd0, r1_err},   64'd1);
        check("oob_rdata",    r1_rdata,          D1);
        check("oob_no_read2", {63'd0, mem_read}, 64'd0);
`else
        check("oob_read",     {63'd0, mem_read}, 64'd1);
        check("oob_addr",     mem_addr,          64'd300);
        tick(); tick();  // v+3
        check("oob_ack",      {63'd0, r1_ack},   64'd1);
        check("oob_err",      {63'd0, r1_err},   64'd0);
`endif
        r1_req = 1'b0;
        tick(); tick();
        check("final_busy",   {63'd0, busy},     64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
